// File: rtl/pool2_ctrl_pkg.sv
// Shared definitions for the pool2 sequencer: default geometry, FSM encoding, address helper.
package pool2_ctrl_pkg;

    localparam int unsigned IN_W_DEF  = 10;
    localparam int unsigned OUT_W_DEF = 5;
    localparam int unsigned F4_AW_DEF = 7;
    localparam int unsigned F5_AW_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Row-major f4 address of element k of window (orow, ocol), full 32-bit arithmetic.
    function automatic int unsigned f4_addr(input int unsigned in_w, input int unsigned orow,
                                            input int unsigned ocol, input logic [1:0] k);
        return (2 * orow + 32'(k[1])) * in_w + 2 * ocol + 32'(k[0]);
    endfunction

endpackage

// File: rtl/pool2_ctrl_if.sv
// Control/address bundle between the pool2 sequencer and its RAMs/datapath.
interface pool2_ctrl_if import pool2_ctrl_pkg::*; #(
    parameter int unsigned F4_AW = F4_AW_DEF,
    parameter int unsigned F5_AW = F5_AW_DEF
);
    logic             pool2_start;
    logic             pool2_busy;
    logic             pool2_done;
    logic             f4_ren;
    logic [F4_AW-1:0] f4_raddr;
    logic             pool2_clr;
    logic             f5_wen;
    logic [F5_AW-1:0] f5_waddr;

    // Sequencer side
    modport master (
        input  pool2_start,
        output pool2_busy, pool2_done, f4_ren, f4_raddr, pool2_clr, f5_wen, f5_waddr
    );

    // Requester / RAM / datapath side
    modport slave (
        output pool2_start,
        input  pool2_busy, pool2_done, f4_ren, f4_raddr, pool2_clr, f5_wen, f5_waddr
    );
endinterface

// File: rtl/pool2_ctrl_pipe_delay.sv
// Fixed-depth shift register with synchronous active-low clear.
module pool2_ctrl_pipe_delay #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [DEPTH*WIDTH-1:0] sr;

    if (DEPTH == 1) begin : g_one
        // Single stage
        always_ff @(posedge clk) begin
            if (!rst_n) sr <= '0;
            else        sr <= din;
        end
    end else begin : g_many
        // Shift towards the MSB end; oldest sample sits at the top
        always_ff @(posedge clk) begin
            if (!rst_n) sr <= '0;
            else        sr <= {sr[(DEPTH-1)*WIDTH-1:0], din};
        end
    end

    assign dout = sr[DEPTH*WIDTH-1 -: WIDTH];
endmodule

// File: rtl/pool2_ctrl.sv
// Pool2 sequencer: walks the f4 map in 2x2 windows and pairs each pooled result with its f5 address.
module pool2_ctrl import pool2_ctrl_pkg::*; #(
    parameter int unsigned IN_W     = IN_W_DEF,
    parameter int unsigned OUT_W    = OUT_W_DEF,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned EXEC_LAT = 1,
    parameter int unsigned F4_AW    = F4_AW_DEF,
    parameter int unsigned F5_AW    = F5_AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    pool2_ctrl_if.master  bus
);
    localparam int unsigned CW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int unsigned WL_D = RD_LAT + EXEC_LAT;

    state_t           state, state_nxt;
    logic [1:0]       k;
    logic [CW-1:0]    ocol, orow;
    logic             last_rd_c;
    logic             busy_d, done_d, ren_d;
    logic             busy_q, done_q, ren_q;
    logic [1:0]       k_q;
    logic [F4_AW-1:0] raddr_q;
    logic [F5_AW-1:0] waddr_q;
    logic             clr_in_c, wen_in_c;
    logic             clr_q, wen_q;
    logic [F5_AW-1:0] f5_waddr_q;

    assign last_rd_c = (k == 2'd3) && (ocol == CW'(OUT_W - 1)) && (orow == CW'(OUT_W - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state and pre-register control outputs
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (bus.pool2_start) state_nxt = ST_READ;
            ST_READ:  if (last_rd_c) state_nxt = ST_DRAIN;
            ST_DRAIN: if (wen_q && (f5_waddr_q == F5_AW'(OUT_W * OUT_W - 1))) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        ren_d  = (state == ST_READ);
        busy_d = (state_nxt == ST_READ) || (state_nxt == ST_DRAIN);
        done_d = (state_nxt == ST_DONE);
    end

    // Window walk: k fastest, then ocol, then orow; parked at zero outside READ
    always_ff @(posedge clk) begin
        if (!rst_n || state != ST_READ) begin
            k    <= '0;
            ocol <= '0;
            orow <= '0;
        end else begin
            k <= k + 2'd1;
            if (k == 2'd3) begin
                if (ocol == CW'(OUT_W - 1)) begin
                    ocol <= '0;
                    orow <= (orow == CW'(OUT_W - 1)) ? '0 : orow + CW'(1);
                end else begin
                    ocol <= ocol + CW'(1);
                end
            end
        end
    end

    // Registered read issue; addresses hold while no read is issued
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ren_q   <= 1'b0;
            k_q     <= '0;
            raddr_q <= '0;
            waddr_q <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            ren_q  <= ren_d;
            k_q    <= k;
            if (ren_d) begin
                raddr_q <= F4_AW'(f4_addr(IN_W, 32'(orow), 32'(ocol), k));
                waddr_q <= F5_AW'(32'(orow) * OUT_W + 32'(ocol));
            end
        end
    end

    assign clr_in_c = ren_q && (k_q == 2'd0);
    assign wen_in_c = ren_q && (k_q == 2'd3);

    pool2_ctrl_pipe_delay #(.DEPTH(RD_LAT), .WIDTH(1)) u_clr_dly (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (clr_in_c),
        .dout (clr_q)
    );

    pool2_ctrl_pipe_delay #(.DEPTH(WL_D), .WIDTH(F5_AW + 1)) u_wen_dly (
        .clk  (clk),
        .rst_n(rst_n),
        .din  ({wen_in_c, waddr_q}),
        .dout ({wen_q, f5_waddr_q})
    );

    assign bus.pool2_busy = busy_q;
    assign bus.pool2_done = done_q;
    assign bus.f4_ren     = ren_q;
    assign bus.f4_raddr   = raddr_q;
    assign bus.pool2_clr  = clr_q;
    assign bus.f5_wen     = wen_q;
    assign bus.f5_waddr   = f5_waddr_q;
endmodule
